// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
//   Buffers pixel writes from the line drawer and feeds them to the VGA write
//   port. Pixels outside the visible area are clipped. A clear-screen sweep
//   drains the FIFO and then paints every pixel in a latched background colour.
//
//   Ports
//     clk, resetn          clock, asynchronous active-low reset
//     in_plot/x/y/colour   pixel strobe and payload from the line drawer
//     in_full              backpressure: FIFO nearly full, or not in RUN
//     clear_req, bg_colour request a clear-screen sweep; colour sampled with it
//     clear_busy           high while flushing or sweeping
//     vga_stall            VGA side cannot accept a pixel this cycle
//     vga_x/y/colour/plot  registered pixel write to the VGA adapter
//
//   Optional build macro PIXEL_STATS_EN adds clip_count and drop_count
//   (16-bit saturating event counters, zeroed on reset and on entry to FLUSH).
//
//   state | meaning
//   RUN   | accept pixels, drain FIFO to VGA
//   FLUSH | no new pixels; drain what is buffered
//   SWEEP | paint (sx,sy) with bg colour, one pixel per unstalled cycle

module pixel_write_buffer #(
  parameter int DEPTH = 16,
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_plot,
  input  logic [8:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_colour,
  output logic       in_full,
  input  logic       clear_req,
  input  logic [2:0] bg_colour,
  output logic       clear_busy,
  input  logic       vga_stall,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
`ifdef PIXEL_STATS_EN
  ,
  output logic [15:0] clip_count,
  output logic [15:0] drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - 1);
  localparam logic [9:0]    X_LIM    = 10'(X_MAX);
  localparam logic [8:0]    Y_LIM    = 9'(Y_MAX);
  localparam logic [8:0]    X_LAST   = 9'(X_MAX - 1);
  localparam logic [7:0]    Y_LAST   = 8'(Y_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      bg_q, bg_d;
  logic [8:0]      sx_q, sx_d;
  logic [7:0]      sy_q, sy_d;
  logic [8:0]      vga_x_q, vga_x_d;
  logic [7:0]      vga_y_q, vga_y_d;
  logic [2:0]      vga_colour_q, vga_colour_d;
  logic            vga_plot_q, vga_plot_d;

  // Entry layout: {x[8:0], y[7:0], colour[2:0]}
  logic [19:0]     mem_q [DEPTH];
  logic [19:0]     head;

  logic            in_range;
  logic            push;
  logic            pop;
  logic            sweep_go;
  logic            sweep_last;

  always_comb begin
    in_range   = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
    // count_q is the pre-pop occupancy, so a same-cycle pop never makes room
    push       = in_plot && (state_q == ST_RUN) && in_range && (count_q < DEPTH_C);
    pop        = (count_q != '0) && !vga_stall && (state_q != ST_SWEEP);
    sweep_go   = (state_q == ST_SWEEP) && !vga_stall;
    sweep_last = (sx_q == X_LAST) && (sy_q == Y_LAST);
    head       = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    unique case (state_q)
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_FLUSH;
          bg_d    = bg_colour;
        end
      end
      ST_FLUSH: begin
        // No pushes happen here, so an empty FIFO also means no pop this cycle
        if (count_q == '0) begin
          state_d = ST_SWEEP;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      ST_SWEEP: begin
        if (sweep_go) begin
          if (sweep_last) begin
            state_d = ST_RUN;
            sx_d    = '0;
            sy_d    = '0;
          end else if (sx_q == X_LAST) begin
            sx_d = '0;
            sy_d = sy_q + 8'd1;
          end else begin
            sx_d = sx_q + 9'd1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    vga_plot_d   = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (pop) begin
      vga_plot_d   = 1'b1;
      vga_x_d      = head[19:11];
      vga_y_d      = head[10:3];
      vga_colour_d = head[2:0];
    end else if (sweep_go) begin
      vga_plot_d   = 1'b1;
      vga_x_d      = sx_q;
      vga_y_d      = sy_q;
      vga_colour_d = bg_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      bg_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      bg_q         <= bg_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says they are valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
  end

  assign in_full    = (count_q >= FULL_THR) || (state_q != ST_RUN);
  assign clear_busy = (state_q != ST_RUN);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

`ifdef PIXEL_STATS_EN
  logic [15:0] clip_q, clip_d;
  logic [15:0] drop_q, drop_d;
  logic        clip_ev;
  logic        drop_ev;
  logic        flush_entry;

  always_comb begin
    clip_ev     = in_plot && !in_range;
    drop_ev     = in_plot && in_range && !push;
    flush_entry = (state_q == ST_RUN) && clear_req;
    clip_d      = clip_q;
    drop_d      = drop_q;
    if (flush_entry) begin
      clip_d = '0;
      drop_d = '0;
    end else begin
      if (clip_ev && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
      if (drop_ev && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_q <= '0;
      drop_q <= '0;
    end else begin
      clip_q <= clip_d;
      drop_q <= drop_d;
    end
  end

  assign clip_count = clip_q;
  assign drop_count = drop_q;
`endif

endmodule
